// File: rtl/mux_4to1_rr_arbiter.sv
// mux_4to1_rr_arbiter
//   Round-robin arbiter and sequencer for a shared 4:1 data multiplexer.
//   The block grants one requester at a time and drives the registered mux
//   selects {s1,s0}. It forwards the selected word to a single consumer over a
//   valid/ready handshake. A grant ends when the owner drops its request, or
//   after MAX_HOLD accepted transfers. At least one idle cycle always separates
//   two grants.
//
// Ports
//   clk        in   1       rising-edge clock
//   rst_n      in   1       synchronous active-low reset
//   req        in   4       per-requester request
//   d0..d3     in   DATA_W  requester data words
//   out_ready  in   1       consumer accepts out_data this cycle
//   grant      out  4       one-hot owner, 0000 when idle
//   s1, s0     out  1       registered mux selects
//   out_data   out  DATA_W  word selected by {s1,s0}
//   out_valid  out  1       owner is granted and still requesting
//   busy       out  1       a grant is active
//
// state    | meaning
// ---------+-------------------------------------------------------------
// ST_IDLE  | no owner; picks the next requester after r_last
// ST_GRANT | owner r_sel holds the mux; counts transfers in r_hold_cnt
module mux_4to1_rr_arbiter #(
  parameter int DATA_W   = 8,
  parameter int MAX_HOLD = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [3:0]        req,
  input  logic [DATA_W-1:0] d0,
  input  logic [DATA_W-1:0] d1,
  input  logic [DATA_W-1:0] d2,
  input  logic [DATA_W-1:0] d3,
  input  logic              out_ready,
  output logic [3:0]        grant,
  output logic              s1,
  output logic              s0,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  output logic              busy
);

  localparam int               CNT_W     = $clog2(MAX_HOLD + 1);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_t;

  state_t           r_state,    w_state_nxt;
  logic [3:0]       r_grant,    w_grant_nxt;
  logic [1:0]       r_sel,      w_sel_nxt;
  logic [CNT_W-1:0] r_hold_cnt, w_hold_cnt_nxt;
  logic [1:0]       r_last,     w_last_nxt;

  logic [1:0] w_pick;
  logic       w_found;
  logic       w_owner_req;
  logic       w_xfer;

  // Search starts one past the last owner; the 2-bit sum wraps mod 4.
  always_comb begin
    w_pick  = 2'd0;
    w_found = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      if (!w_found && req[r_last + 2'(k)]) begin
        w_found = 1'b1;
        w_pick  = r_last + 2'(k);
      end
    end
  end

  // While granted, r_sel holds the owner index.
  assign w_owner_req = req[r_sel];
  assign w_xfer      = out_valid && out_ready;

  always_comb begin
    w_state_nxt    = r_state;
    w_grant_nxt    = r_grant;
    w_sel_nxt      = r_sel;
    w_hold_cnt_nxt = r_hold_cnt;
    w_last_nxt     = r_last;
    case (r_state)
      ST_IDLE: begin
        if (w_found) begin
          w_state_nxt    = ST_GRANT;
          w_grant_nxt    = 4'b0001 << w_pick;
          w_sel_nxt      = w_pick;
          w_hold_cnt_nxt = '0;
        end
      end
      ST_GRANT: begin
        if (w_xfer) begin
          w_hold_cnt_nxt = r_hold_cnt + CNT_W'(1);
        end
        // Selects keep their value on release so out_data does not move.
        if (!w_owner_req || (w_xfer && (r_hold_cnt == HOLD_LAST))) begin
          w_state_nxt    = ST_IDLE;
          w_grant_nxt    = 4'b0000;
          w_hold_cnt_nxt = '0;
          w_last_nxt     = r_sel;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_grant_nxt = 4'b0000;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_grant    <= 4'b0000;
      r_sel      <= 2'd0;
      r_hold_cnt <= '0;
      r_last     <= 2'd3;
    end else begin
      r_state    <= w_state_nxt;
      r_grant    <= w_grant_nxt;
      r_sel      <= w_sel_nxt;
      r_hold_cnt <= w_hold_cnt_nxt;
      r_last     <= w_last_nxt;
    end
  end

  always_comb begin
    case (r_sel)
      2'd0:    out_data = d0;
      2'd1:    out_data = d1;
      2'd2:    out_data = d2;
      default: out_data = d3;
    endcase
  end

  assign grant     = r_grant;
  assign s1        = r_sel[1];
  assign s0        = r_sel[0];
  assign busy      = (r_state == ST_GRANT);
  assign out_valid = (r_state == ST_GRANT) && w_owner_req;

endmodule

// File: tb/tb_mux_4to1_rr_arbiter.sv
module tb_mux_4to1_rr_arbiter;
  localparam int DATA_W   = 8;
  localparam int MAX_HOLD = 4;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [3:0]        req;
  logic [DATA_W-1:0] d0, d1, d2, d3;
  logic              out_ready;
  logic [3:0]        grant;
  logic              s1, s0;
  logic [DATA_W-1:0] out_data;
  logic              out_valid;
  logic              busy;

  mux_4to1_rr_arbiter #(.DATA_W(DATA_W), .MAX_HOLD(MAX_HOLD)) dut (
    .clk(clk), .rst_n(rst_n), .req(req),
    .d0(d0), .d1(d1), .d2(d2), .d3(d3),
    .out_ready(out_ready), .grant(grant), .s1(s1), .s0(s0),
    .out_data(out_data), .out_valid(out_valid), .busy(busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [3:0]        grant;
    logic [1:0]        sel;
    logic              valid;
    logic              busy;
    logic [DATA_W-1:0] data;
  } stat_t;
  typedef struct {
    logic [3:0]        grant;
    logic [DATA_W-1:0] data;
  } xfer_t;

  stat_t stat_q[$];
  xfer_t xfer_q[$];

  logic [DATA_W-1:0] td [4];

  // Reference model: owner index, accepted-transfer count, last owner.
  bit m_busy  = 1'b0;
  int m_owner = 0;
  int m_sel   = 0;
  int m_cnt   = 0;
  int m_last  = 3;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // Applies one cycle of stimulus, records what the model expects to see
  // during that cycle, then advances the model across the coming edge.
  task automatic drive(input bit rst, input logic [3:0] rq, input bit rdy_in);
    stat_t s;
    xfer_t x;
    bit    v;
    bit    rdy;
    int    pick;
    @(posedge clk);
    #1;
    rdy       = rst ? rdy_in : 1'b0;
    rst_n     = rst;
    req       = rq;
    out_ready = rdy;
    d0 = td[0]; d1 = td[1]; d2 = td[2]; d3 = td[3];

    v       = m_busy && rq[m_owner];
    s.grant = m_busy ? 4'(1 << m_owner) : 4'b0000;
    s.sel   = 2'(m_sel);
    s.valid = v;
    s.busy  = m_busy;
    s.data  = td[m_sel];
    stat_q.push_back(s);
    if (v && rdy) begin
      x.grant = s.grant;
      x.data  = td[m_owner];
      xfer_q.push_back(x);
    end

    if (!rst) begin
      m_busy = 1'b0; m_sel = 0; m_cnt = 0; m_last = 3;
    end else if (!m_busy) begin
      if (rq != 4'b0000) begin
        pick = 0;
        for (int k = 1; k <= 4; k++) begin
          if (rq[(m_last + k) % 4]) begin
            pick = (m_last + k) % 4;
            break;
          end
        end
        m_busy = 1'b1; m_owner = pick; m_sel = pick; m_cnt = 0;
      end
    end else begin
      if (v && rdy) m_cnt++;
      if (!rq[m_owner] || m_cnt == MAX_HOLD) begin
        m_busy = 1'b0;
        m_last = m_owner;
      end
    end
  endtask

  // Monitor: per-cycle status and scoreboarded transfers.
  always @(negedge clk) begin
    stat_t s;
    xfer_t x;
    if (stat_q.size() > 0) begin
      s = stat_q.pop_front();
      check("grant", 32'(grant), 32'(s.grant));
      check("sel", 32'({s1, s0}), 32'(s.sel));
      check("out_valid", 32'(out_valid), 32'(s.valid));
      check("busy", 32'(busy), 32'(s.busy));
      if (s.busy) check("out_data", 32'(out_data), 32'(s.data));
    end
    if (out_valid === 1'b1 && out_ready === 1'b1) begin
      if (xfer_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL xfer_unexpected: got grant %b data %0h expected no transfer", grant, out_data);
      end else begin
        x = xfer_q.pop_front();
        check("xfer_owner", 32'(grant), 32'(x.grant));
        check("xfer_data", 32'(out_data), 32'(x.data));
      end
    end
  end

  initial begin
    logic [3:0] rq;
    rst_n = 1'b0; req = 4'b0000; out_ready = 1'b0;
    for (int j = 0; j < 4; j++) td[j] = 8'($urandom);
    d0 = td[0]; d1 = td[1]; d2 = td[2]; d3 = td[3];

    // T1: reset with all requests high
    drive(1'b0, 4'b1111, 1'b1);
    drive(1'b0, 4'b1111, 1'b1);
    drive(1'b1, 4'b0000, 1'b0);
    @(negedge clk);
    check("t1_grant", 32'(grant), 32'h0);
    check("t1_sel", 32'({s1, s0}), 32'h0);
    check("t1_valid", 32'(out_valid), 32'h0);
    check("t1_busy", 32'(busy), 32'h0);

    // T2: single requester 2
    td[2] = 8'hA5;
    drive(1'b1, 4'b0100, 1'b1);
    drive(1'b1, 4'b0100, 1'b1);
    @(negedge clk);
    check("t2_grant", 32'(grant), 32'h4);
    check("t2_sel", 32'({s1, s0}), 32'h2);
    check("t2_data", 32'(out_data), 32'hA5);
    check("t2_valid", 32'(out_valid), 32'h1);
    drive(1'b1, 4'b0000, 1'b1);
    drive(1'b1, 4'b0000, 1'b1);
    @(negedge clk);
    check("t2_release", 32'(grant), 32'h0);

    // T3: all requesting; 4 transfers per grant, one idle bubble between
    drive(1'b0, 4'b0000, 1'b0);
    for (int c = 0; c < 22; c++) begin
      drive(1'b1, 4'b1111, 1'b1);
      @(negedge clk);
      check("t3_grant", 32'(grant),
            (c % 5 == 0) ? 32'h0 : 32'(1 << ((c / 5) % 4)));
    end

    // T4: owner 1, one transfer, 3 stalled cycles, 3 more transfers
    drive(1'b0, 4'b0000, 1'b0);
    drive(1'b1, 4'b0010, 1'b0);
    drive(1'b1, 4'b0010, 1'b1);
    for (int c = 0; c < 3; c++) begin
      drive(1'b1, 4'b0010, 1'b0);
      @(negedge clk);
      check("t4_stall_grant", 32'(grant), 32'h2);
    end
    for (int c = 0; c < 3; c++) begin
      drive(1'b1, 4'b0010, 1'b1);
      @(negedge clk);
      check("t4_xfer_grant", 32'(grant), 32'h2);
    end
    drive(1'b1, 4'b0010, 1'b1);
    @(negedge clk);
    check("t4_release", 32'(grant), 32'h0);

    // T5: reset during grant of owner 2
    drive(1'b0, 4'b0000, 1'b0);
    drive(1'b1, 4'b0100, 1'b0);
    drive(1'b1, 4'b0100, 1'b0);
    @(negedge clk);
    check("t5_grant", 32'(grant), 32'h4);
    drive(1'b0, 4'b0100, 1'b0);
    drive(1'b1, 4'b1111, 1'b0);
    @(negedge clk);
    check("t5_after_rst", 32'(grant), 32'h0);
    drive(1'b1, 4'b1111, 1'b0);
    @(negedge clk);
    check("t5_regrant", 32'(grant), 32'h1);

    // T6: last=1, req=1010 -> requester 3
    drive(1'b0, 4'b0000, 1'b0);
    drive(1'b1, 4'b0010, 1'b1);
    drive(1'b1, 4'b0010, 1'b1);
    drive(1'b1, 4'b0000, 1'b1);
    drive(1'b1, 4'b1010, 1'b0);
    drive(1'b1, 4'b1010, 1'b0);
    @(negedge clk);
    check("t6_grant", 32'(grant), 32'h8);
    check("t6_sel", 32'({s1, s0}), 32'h3);

    // Randomized traffic with sticky requests and occasional reset
    rq = 4'b1111;
    for (int n = 0; n < 3000; n++) begin
      for (int j = 0; j < 4; j++) begin
        if ($urandom_range(4) == 0) td[j] = 8'($urandom);
        if ($urandom_range(5) == 0) rq[j] = ~rq[j];
      end
      drive($urandom_range(99) != 0, rq, $urandom_range(3) != 0);
    end
    drive(1'b1, 4'b0000, 1'b0);
    @(negedge clk);
    #1;
    check("xfer_q_drained", 32'(xfer_q.size()), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
